// File: rtl/mul_share_arb.sv
// Two-client front end for one shared n x n multiplier.
// Round-robin grant, operand capture, fixed-latency countdown, held result with requester tag.
module mul_share_arb #(
  parameter int n   = 8,
  parameter int lat = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_vld,
  output logic           req0_rdy,
  input  logic [n-1:0]   req0_a,
  input  logic [n-1:0]   req0_b,
  input  logic           req0_sign,
  input  logic           req1_vld,
  output logic           req1_rdy,
  input  logic [n-1:0]   req1_a,
  input  logic [n-1:0]   req1_b,
  input  logic           req1_sign,
  output logic           res_vld,
  input  logic           res_rdy,
  output logic [2*n-1:0] res,
  output logic           res_id,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [n-1:0]     a_q, a_d, b_q, b_d;
  logic             sign_q, sign_d, id_q, id_d;
  logic             last_q, last_d;
  logic [2*n-1:0]   res_q, res_d;
  logic             res_id_q, res_id_d;
  logic             grant_vld, grant_id, accept;

  // Extend both operands to 2n bits; the low 2n bits of the product are exact either way.
  function automatic logic [2*n-1:0] mul_ext(input logic [n-1:0] a, input logic [n-1:0] b,
                                             input logic s);
    logic signed [2*n-1:0] ea, eb, p;
    ea = s ? signed'({{n{a[n-1]}}, a}) : signed'({{n{1'b0}}, a});
    eb = s ? signed'({{n{b[n-1]}}, b}) : signed'({{n{1'b0}}, b});
    p  = ea * eb;
    return p;
  endfunction

  // On a tie the requester that did not win last time gets the grant.
  assign grant_vld = req0_vld | req1_vld;
  assign grant_id  = (req0_vld && req1_vld) ? ~last_q : req1_vld;
  assign accept    = (state_q == IDLE) && grant_vld && rst_n;
  assign req0_rdy  = accept && !grant_id;
  assign req1_rdy  = accept && grant_id;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    id_d     = id_q;
    last_d   = last_q;
    res_d    = res_q;
    res_id_d = res_id_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          a_d     = grant_id ? req1_a    : req0_a;
          b_d     = grant_id ? req1_b    : req0_b;
          sign_d  = grant_id ? req1_sign : req0_sign;
          id_d    = grant_id;
          last_d  = grant_id;
          cnt_d   = 4'(lat - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == 4'd0) begin
          res_d    = mul_ext(a_q, b_q, sign_q);
          res_id_d = id_q;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (res_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      last_q   <= 1'b1;
      res_q    <= '0;
      res_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      res_q    <= res_d;
      res_id_q <= res_id_d;
    end
  end

  // Captured operands are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    sign_q <= sign_d;
    id_q   <= id_d;
  end

  assign res_vld = (state_q == DONE);
  assign busy    = (state_q != IDLE);
  assign res     = res_q;
  assign res_id  = res_id_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Randomized and directed checks of mul_share_arb against a transaction-level model
// (arbitration rule, accept timestamp + latency, integer-arithmetic products).
module tb_mul_share_arb;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req0_vld, req0_rdy, req0_sign, req1_vld, req1_rdy, req1_sign;
  logic [N-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           res_vld, res_rdy, res_id, busy;
  logic [2*N-1:0] res;

  logic           x_vld, x_sign;
  logic [N-1:0]   x_a, x_b;
  logic           x1_rdy0, x1_rdy1, x1_vld, x1_id, x1_busy;
  logic           x15_rdy0, x15_rdy1, x15_vld, x15_id, x15_busy;
  logic [2*N-1:0] x1_res, x15_res;

  always #5 clk = ~clk;

  mul_share_arb #(.n(N), .lat(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_a(req0_a), .req0_b(req0_b), .req0_sign(req0_sign),
    .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_a(req1_a), .req1_b(req1_b), .req1_sign(req1_sign),
    .res_vld(res_vld), .res_rdy(res_rdy), .res(res), .res_id(res_id), .busy(busy)
  );

  mul_share_arb #(.n(N), .lat(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req0_vld(x_vld), .req0_rdy(x1_rdy0), .req0_a(x_a), .req0_b(x_b), .req0_sign(x_sign),
    .req1_vld(1'b0), .req1_rdy(x1_rdy1), .req1_a(x_a), .req1_b(x_b), .req1_sign(1'b0),
    .res_vld(x1_vld), .res_rdy(1'b1), .res(x1_res), .res_id(x1_id), .busy(x1_busy)
  );

  mul_share_arb #(.n(N), .lat(15)) u_lat15 (
    .clk(clk), .rst_n(rst_n),
    .req0_vld(x_vld), .req0_rdy(x15_rdy0), .req0_a(x_a), .req0_b(x_b), .req0_sign(x_sign),
    .req1_vld(1'b0), .req1_rdy(x15_rdy1), .req1_a(x_a), .req1_b(x_b), .req1_sign(1'b0),
    .res_vld(x15_vld), .res_rdy(1'b1), .res(x15_res), .res_id(x15_id), .busy(x15_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic s);
    int x, y, p;
    x = int'(a);
    y = int'(b);
    if (s && a[N-1]) x = x - (1 << N);
    if (s && b[N-1]) y = y - (1 << N);
    p = x * y;
    return p[2*N-1:0];
  endfunction

  // Transaction model: one op in flight, result due LAT edges after its accept edge.
  bit             m_busy, m_last, m_id;
  int             m_cyc, m_acc;
  logic [2*N-1:0] m_res;
  bit             obs_vld, obs_rdy0, obs_rdy1, obs_id;
  logic [2*N-1:0] obs_res;

  task automatic model_reset();
    m_busy = 0; m_last = 1; m_id = 0; m_cyc = 0; m_acc = 0; m_res = '0;
  endtask

  task automatic cycle(input bit v0, input bit v1,
                       input logic [N-1:0] a0, input logic [N-1:0] b0, input bit s0,
                       input logic [N-1:0] a1, input logic [N-1:0] b1, input bit s1,
                       input bit rr);
    bit g_any, g_id, e_vld;
    req0_vld = v0; req0_a = a0; req0_b = b0; req0_sign = s0;
    req1_vld = v1; req1_a = a1; req1_b = b1; req1_sign = s1;
    res_rdy  = rr;
    #1;
    g_any = !m_busy && (v0 || v1);
    g_id  = (v0 && v1) ? !m_last : v1;
    e_vld = m_busy && (m_cyc - m_acc > LAT);
    check("rdy0", req0_rdy, 32'(g_any && !g_id));
    check("rdy1", req1_rdy, 32'(g_any && g_id));
    check("res_vld", res_vld, 32'(e_vld));
    check("busy", busy, 32'(m_busy));
    if (e_vld) begin
      check("res", res, m_res);
      check("res_id", res_id, 32'(m_id));
    end
    obs_vld = res_vld; obs_rdy0 = req0_rdy; obs_rdy1 = req1_rdy;
    obs_res = res; obs_id = res_id;
    @(posedge clk);
    if (e_vld && rr) m_busy = 0;
    else if (g_any) begin
      m_busy = 1; m_acc = m_cyc; m_last = g_id; m_id = g_id;
      m_res  = g_id ? ref_mul(a1, b1, s1) : ref_mul(a0, b0, s0);
    end
    m_cyc++;
    #1;
  endtask

  task automatic drain();
    repeat (LAT + 4) cycle(0, 0, '0, '0, 0, '0, '0, 0, 1);
  endtask

  task automatic do_op(input bit id, input logic [N-1:0] a, input logic [N-1:0] b, input bit s,
                       output logic [2*N-1:0] r, output bit rid);
    int seen;
    if (id) cycle(0, 1, '0, '0, 0, a, b, s, 1);
    else    cycle(1, 0, a, b, s, '0, '0, 0, 1);
    check("op_accept", id ? obs_rdy1 : obs_rdy0, 1);
    seen = -1;
    for (int k = 0; k < 20; k++) begin
      cycle(0, 0, '0, '0, 0, '0, '0, 0, 1);
      if (obs_vld) begin seen = k; break; end
    end
    check("op_latency", seen, LAT);
    r = obs_res; rid = obs_id;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*N-1:0] r;
    bit             rid;
    bit             gq[$];
    int             cnt, f1, f15;
    logic [N-1:0]   ta[5], tb_[5];
    bit             ts[5];
    logic [2*N-1:0] te[5];

    req0_vld = 0; req1_vld = 0; req0_a = '0; req0_b = '0; req0_sign = 0;
    req1_a = '0; req1_b = '0; req1_sign = 0; res_rdy = 0;
    x_vld = 0; x_a = '0; x_b = '0; x_sign = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_res_vld", res_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_res", res, 0);
    check("rst_res_id", res_id, 0);
    req0_vld = 1; req1_vld = 1;
    #1;
    check("rst_rdy0", req0_rdy, 0);
    check("rst_rdy1", req1_rdy, 0);
    req0_vld = 0; req1_vld = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;

    // Both requesters continuously valid from reset: grants must alternate starting with 0.
    repeat (6 * (LAT + 2)) begin
      cycle(1, 1, N'($urandom), N'($urandom), 1'($urandom), N'($urandom), N'($urandom),
            1'($urandom), 1);
      if (obs_rdy0) gq.push_back(0);
      else if (obs_rdy1) gq.push_back(1);
    end
    check("alt_count", gq.size(), 6);
    if (gq.size() > 0) check("alt_first", gq[0], 0);
    for (int i = 1; i < gq.size(); i++) check("alt_next", gq[i], !gq[i-1]);
    drain();

    do_op(0, 4'hF, 4'hF, 0, r, rid);
    check("u15x15_res", r, 8'hE1);
    check("u15x15_id", rid, 0);
    ta = '{4'hF, 4'h8, 4'h8, 4'h8, 4'hF};
    tb_ = '{4'hF, 4'h8, 4'h7, 4'h8, 4'h1};
    ts = '{1, 1, 1, 0, 0};
    te = '{8'h01, 8'h40, 8'hC8, 8'h40, 8'h0F};
    for (int i = 0; i < 5; i++) begin
      do_op(1, ta[i], tb_[i], ts[i], r, rid);
      check("dir_res", r, te[i]);
      check("dir_id", rid, 1);
    end

    // Backpressure: result held five cycles with both requesters knocking.
    cycle(1, 0, 4'h3, 4'h5, 0, '0, '0, 0, 0);
    check("bp_accept", obs_rdy0, 1);
    cnt = 0;
    repeat (LAT + 5) begin
      cycle(1, 1, 4'h1, 4'h1, 0, 4'h2, 4'h2, 0, 0);
      if (obs_vld) begin
        cnt++;
        check("bp_res", obs_res, 8'h0F);
        check("bp_busy", busy, 1);
      end
    end
    check("bp_done_cycles", cnt, 5);
    cycle(0, 0, '0, '0, 0, '0, '0, 0, 1);
    check("bp_take", obs_vld, 1);
    cycle(1, 0, 4'h2, 4'h3, 0, '0, '0, 0, 1);
    check("bp_next_accept", obs_rdy0, 1);
    drain();

    // Reset pulsed while an operation is in CALC.
    cycle(1, 0, 4'h9, 4'h9, 1, '0, '0, 0, 1);
    req0_vld = 1; req1_vld = 1;
    #1 rst_n = 0;
    #1;
    check("mid_rst_res_vld", res_vld, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_res", res, 0);
    check("mid_rst_rdy0", req0_rdy, 0);
    check("mid_rst_rdy1", req1_rdy, 0);
    model_reset();
    req0_vld = 0; req1_vld = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    cycle(1, 1, 4'h2, 4'h6, 0, 4'h3, 4'h7, 0, 1);
    check("rst_first_grant0", obs_rdy0, 1);
    drain();

    repeat (600)
      cycle(1'($urandom), 1'($urandom), N'($urandom), N'($urandom), 1'($urandom),
            N'($urandom), N'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
    drain();

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < (1 << N); a++)
        for (int b = 0; b < (1 << N); b++) begin
          do_op(1'((a ^ b) & 1), N'(a), N'(b), 1'(s), r, rid);
          check("sweep", r, ref_mul(N'(a), N'(b), 1'(s)));
        end
    drain();

    // lat=1 and lat=15 builds side by side.
    x_vld = 1; x_a = 4'hD; x_b = 4'h3; x_sign = 1;
    #1;
    check("x1_accept", x1_rdy0, 1);
    check("x15_accept", x15_rdy0, 1);
    @(posedge clk);
    #1;
    x_vld = 0;
    f1 = -1; f15 = -1;
    for (int k = 1; k <= 20; k++) begin
      if (f1 < 0 && x1_vld) f1 = k - 1;
      if (f15 < 0 && x15_vld) f15 = k - 1;
      @(posedge clk);
      #1;
    end
    check("x1_latency", f1, 1);
    check("x15_latency", f15, 15);
    check("x1_res", x1_res, ref_mul(4'hD, 4'h3, 1));
    check("x15_res", x15_res, ref_mul(4'hD, 4'h3, 1));
    check("x15_id", x15_id, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
